// File: rtl/ps2_tx_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
package ps2_tx_pkg;

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RTS, WAIT_FIRST, SEND, RELEASE, DONE, ERROR
  } tx_state_e;

  // Bit order on the wire after the start bit: data LSB first, parity, stop.
  typedef struct packed {
    logic       stop;
    logic       parity;
    logic [7:0] data;
  } tx_frame_t;

  localparam int DEF_INHIBIT_CYCLES       = 5000;
  localparam int DEF_START_TIMEOUT_CYCLES = 750000;
  localparam int DEF_BIT_TIMEOUT_CYCLES   = 100000;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

  function automatic tx_frame_t make_frame(input logic [7:0] b);
    make_frame.stop   = 1'b1;
    make_frame.parity = ~^b;
    make_frame.data   = b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for PS2_CLK/PS2_DAT plus a registered clock falling-edge
// strobe. Flops reset to the idle-high line level so reset never fakes an edge.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic clk_raw,
  input  logic dat_raw,
  output logic clk_sync,
  output logic dat_sync,
  output logic clk_fall
);

  logic [1:0] clk_ff;
  logic [1:0] dat_ff;
  logic       clk_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_ff   <= 2'b11;
      dat_ff   <= 2'b11;
      clk_d    <= 1'b1;
      clk_fall <= 1'b0;
    end else begin
      clk_ff   <= {clk_ff[0], clk_raw};
      dat_ff   <= {dat_ff[0], dat_raw};
      clk_d    <= clk_ff[1];
      clk_fall <= clk_d & ~clk_ff[1];
    end
  end

  assign clk_sync = clk_ff[1];
  assign dat_sync = dat_ff[1];

endmodule

// File: rtl/ps2_command_out.sv
// PS/2 host-to-device command transmitter (inhibit, request-to-send, 11-bit frame, ack).
// Define PS2_TX_RETRY_EN to retry a failed frame up to twice before reporting an error.
module ps2_command_out
  import ps2_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES       = DEF_INHIBIT_CYCLES,
  parameter int START_TIMEOUT_CYCLES = DEF_START_TIMEOUT_CYCLES,
  parameter int BIT_TIMEOUT_CYCLES   = DEF_BIT_TIMEOUT_CYCLES
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] command_byte,
  input  logic       send_command,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       command_was_sent,
  output logic       error_communication_timed_out
);

  localparam int TMO_MAX = (START_TIMEOUT_CYCLES > BIT_TIMEOUT_CYCLES) ?
                           START_TIMEOUT_CYCLES : BIT_TIMEOUT_CYCLES;
  localparam int TMO_W   = $clog2(TMO_MAX + 1);
  localparam int INH_W   = $clog2(INHIBIT_CYCLES + 1);

  tx_state_e        state, state_nxt;
  tx_frame_t        frame;
  logic [9:0]       frame_bits;
  logic [3:0]       bit_cnt;
  logic             tx_bit;
  logic [INH_W-1:0] inh_cnt;
  logic [TMO_W-1:0] tmo_cnt, tmo_lim;
  logic             tmo_hit, tmo_clr, fail, retry_left;
  logic             clk_s, dat_s, clk_fall;

  ps2_line_sync u_sync (
    .clk      (CLOCK_50),
    .rst      (reset),
    .clk_raw  (ps2_clk_in),
    .dat_raw  (ps2_dat_in),
    .clk_sync (clk_s),
    .dat_sync (dat_s),
    .clk_fall (clk_fall)
  );

  assign frame_bits = frame;
  assign tmo_lim    = (state == WAIT_FIRST) ? TMO_W'(START_TIMEOUT_CYCLES - 1)
                                            : TMO_W'(BIT_TIMEOUT_CYCLES - 1);
  assign tmo_hit    = (tmo_cnt >= tmo_lim);

`ifdef PS2_TX_RETRY_EN
  logic [1:0] retry_cnt;
  assign retry_left = (retry_cnt != 2'd2);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)                               retry_cnt <= 2'd0;
    else if (state == IDLE && send_command)  retry_cnt <= 2'd0;
    else if (fail && retry_left)             retry_cnt <= retry_cnt + 2'd1;
  end
`else
  assign retry_left = 1'b0;
`endif

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt                     = state;
    ps2_clk_oe                    = 1'b0;
    ps2_dat_oe                    = 1'b0;
    busy                          = 1'b1;
    command_was_sent              = 1'b0;
    error_communication_timed_out = 1'b0;
    tmo_clr                       = 1'b0;
    fail                          = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (send_command) state_nxt = INHIBIT;
      end
      INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) state_nxt = RTS;
      end
      RTS: begin
        ps2_clk_oe = 1'b1;
        ps2_dat_oe = 1'b1;
        tmo_clr    = 1'b1;
        state_nxt  = WAIT_FIRST;
      end
      WAIT_FIRST: begin
        ps2_dat_oe = 1'b1;
        if (clk_fall) begin
          tmo_clr   = 1'b1;
          state_nxt = SEND;
        end else if (tmo_hit) begin
          fail = 1'b1;
        end
      end
      SEND: begin
        ps2_dat_oe = ~tx_bit;
        // An edge always beats a timeout landing in the same cycle.
        if (clk_fall) begin
          tmo_clr = 1'b1;
          if (bit_cnt == 4'd10) begin
            if (!dat_s) state_nxt = RELEASE;
            else        fail      = 1'b1;
          end
        end else if (tmo_hit) begin
          fail = 1'b1;
        end
      end
      RELEASE: begin
        if (clk_s && dat_s) state_nxt = DONE;
        else if (tmo_hit)   fail      = 1'b1;
      end
      DONE: begin
        busy             = 1'b0;
        command_was_sent = 1'b1;
        state_nxt        = IDLE;
      end
      ERROR: begin
        busy                          = 1'b0;
        error_communication_timed_out = 1'b1;
        state_nxt                     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (fail) state_nxt = retry_left ? INHIBIT : ERROR;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      frame   <= '0;
      bit_cnt <= 4'd0;
      tx_bit  <= 1'b1;
      inh_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      if (state == IDLE && send_command) frame <= make_frame(command_byte);

      inh_cnt <= (state == INHIBIT && state_nxt == INHIBIT) ? inh_cnt + 1'b1 : '0;

      if (tmo_clr)                          tmo_cnt <= '0;
      else if (tmo_cnt != TMO_W'(TMO_MAX))  tmo_cnt <= tmo_cnt + 1'b1;

      // bit_cnt = edges seen so far; edge k puts frame bit k-1 on the line.
      if (state == RTS) begin
        bit_cnt <= 4'd0;
        tx_bit  <= 1'b0;
      end else if (clk_fall && (state == WAIT_FIRST || state == SEND) && bit_cnt != 4'd10) begin
        tx_bit  <= frame_bits[bit_cnt];
        bit_cnt <= bit_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_command_out.sv
// Directed bench for ps2_command_out with a simple PS/2 device model on the pins.
module tb_ps2_command_out;
  import ps2_tx_pkg::*;

  localparam int INH   = 5000;
  localparam int START = 2000;
  localparam int BIT   = 500;
  localparam int HALF  = 40;
`ifdef PS2_TX_RETRY_EN
  localparam int FRAMES_ON_FAIL = 3;
`else
  localparam int FRAMES_ON_FAIL = 1;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] command_byte = 8'h00;
  logic       send_command = 1'b0;
  logic       dev_clk = 1'b1, dev_dat = 1'b1;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_oe, ps2_dat_oe, busy, command_was_sent, error_communication_timed_out;

  int n_tests = 0, n_fail = 0;
  int n_sent = 0, n_err = 0;
  int cyc = 0, rts_cyc = 0, err_cyc = 0, inh_run = 0, last_inh = 0;
  logic prev_busy = 1'b0;
  logic [10:0] seen;
  int b_sent, b_err;

  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  always #5 CLOCK_50 = ~CLOCK_50;

  ps2_command_out #(
    .INHIBIT_CYCLES(INH), .START_TIMEOUT_CYCLES(START), .BIT_TIMEOUT_CYCLES(BIT)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .command_byte(command_byte), .send_command(send_command),
    .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe), .busy(busy),
    .command_was_sent(command_was_sent),
    .error_communication_timed_out(error_communication_timed_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge CLOCK_50) begin
    cyc++;
    if (ps2_clk_oe && ps2_dat_oe) rts_cyc = cyc;
    if (ps2_clk_oe && !ps2_dat_oe) inh_run++;
    else if (inh_run != 0) begin last_inh = inh_run; inh_run = 0; end
    if (command_was_sent || error_communication_timed_out) begin
      chk("pulse_excl", {31'd0, command_was_sent & error_communication_timed_out}, 0);
      chk("busy_low_at_end", {31'd0, busy}, 0);
      chk("busy_high_before_end", {31'd0, prev_busy}, 1);
    end
    if (command_was_sent) n_sent++;
    if (error_communication_timed_out) begin n_err++; err_cyc = cyc; end
    prev_busy = busy;
  end

  task automatic send(input logic [7:0] b);
    @(negedge CLOCK_50);
    command_byte = b;
    send_command = 1'b1;
    @(negedge CLOCK_50);
    send_command = 1'b0;
  endtask

  task automatic dev_frame(input int n_edges, input bit ack, output logic [10:0] s);
    int w = 0;
    s = '0;
    while (!(ps2_dat_oe && !ps2_clk_oe) && w < 20000) begin
      @(negedge CLOCK_50);
      w++;
    end
    chk("rts_seen", {31'd0, w < 20000}, 1);
    repeat (20) @(negedge CLOCK_50);
    for (int i = 0; i < n_edges; i++) begin
      if (i == 10 && ack) dev_dat = 1'b0;
      dev_clk = 1'b0;
      repeat (HALF) @(negedge CLOCK_50);
      s[i] = ps2_dat_in;
      dev_clk = 1'b1;
      repeat (HALF) @(negedge CLOCK_50);
    end
    dev_dat = 1'b1;
  endtask

  task automatic wait_result(input int max_cyc);
    int w = 0;
    while ((n_sent + n_err) == (b_sent + b_err) && w < max_cyc) begin
      @(negedge CLOCK_50);
      w++;
    end
    chk("result_in_time", {31'd0, w < max_cyc}, 1);
    repeat (10) @(negedge CLOCK_50);
  endtask

  task automatic good_frame(input string tag, input logic [7:0] b, input logic par);
    b_sent = n_sent; b_err = n_err;
    send(b);
    dev_frame(11, 1'b1, seen);
    wait_result(1000);
    chk({tag, "_data"}, {24'd0, seen[7:0]}, {24'd0, b});
    chk({tag, "_parity"}, {31'd0, seen[8]}, {31'd0, par});
    chk({tag, "_stop"}, {31'd0, seen[9]}, 1);
    chk({tag, "_sent"}, n_sent - b_sent, 1);
    chk({tag, "_err"}, n_err - b_err, 0);
  endtask

  initial begin
    repeat (5) @(negedge CLOCK_50);
    chk("reset_outputs", {27'd0, ps2_clk_oe, ps2_dat_oe, busy, command_was_sent,
                          error_communication_timed_out}, 0);
    reset = 1'b0;
    repeat (5) @(negedge CLOCK_50);

    good_frame("ed", PS2_CMD_SET_LEDS, 1'b1);
    chk("ed_inhibit_len", last_inh, INH);

    good_frame("f4", PS2_CMD_ENABLE, 1'b0);
    chk("f4_inhibit_len", last_inh, INH);

    // Device never clocks.
    b_sent = n_sent; b_err = n_err;
    send(PS2_CMD_RESET);
    wait_result(30000);
    chk("noclk_err", n_err - b_err, 1);
    chk("noclk_sent", n_sent - b_sent, 0);
    chk("noclk_latency", err_cyc - rts_cyc, START + 1);
    chk("noclk_lines", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);

    // Device clocks but withholds ack.
    b_sent = n_sent; b_err = n_err;
    send(PS2_CMD_SET_LEDS);
    for (int f = 0; f < FRAMES_ON_FAIL; f++) dev_frame(11, 1'b0, seen);
    wait_result(2000);
    chk("noack_err", n_err - b_err, 1);
    chk("noack_sent", n_sent - b_sent, 0);
    chk("noack_data", {24'd0, seen[7:0]}, 32'hED);

    // Reset in the middle of a frame.
    b_sent = n_sent; b_err = n_err;
    send(PS2_CMD_SET_LEDS);
    dev_frame(5, 1'b0, seen);
    chk("mid_busy_before_reset", {31'd0, busy}, 1);
    #2 reset = 1'b1;
    #1 chk("mid_reset_async", {29'd0, ps2_clk_oe, ps2_dat_oe, busy}, 0);
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    chk("mid_no_pulse", (n_sent - b_sent) + (n_err - b_err), 0);
    good_frame("ff", PS2_CMD_RESET, 1'b1);

    // send_command while busy is ignored.
    b_sent = n_sent; b_err = n_err;
    send(PS2_CMD_SET_LEDS);
    repeat (100) @(negedge CLOCK_50);
    send(8'h00);
    dev_frame(11, 1'b1, seen);
    wait_result(1000);
    repeat (200) @(negedge CLOCK_50);
    chk("busy_ign_data", {24'd0, seen[7:0]}, 32'hED);
    chk("busy_ign_sent", n_sent - b_sent, 1);
    chk("busy_ign_idle", {31'd0, busy}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
